// File: rtl/spi_frame_receiver_pkg.sv
// Shared constants and types for the SPI frame receiver that feeds the
// HUB75 panel frame buffer.
//  PANEL_COLUMNS / PANEL_ROW_PAIRS : panel geometry
//  PIXEL_COUNT / PIXEL_ADDR_W      : pixels per frame and pixel index width
//  BITS_PER_PIXEL / SYNC_STAGES    : default receiver parameters
//  rx_state_e                      : receiver FSM states
`timescale 1ns/1ps
package spi_frame_receiver_pkg;
    localparam int PANEL_COLUMNS   = 64;
    localparam int PANEL_ROW_PAIRS = 16;
    localparam int PIXEL_COUNT     = PANEL_COLUMNS * PANEL_ROW_PAIRS;
    localparam int PIXEL_ADDR_W    = $clog2(PIXEL_COUNT);
    localparam int BITS_PER_PIXEL  = 16;
    localparam int SYNC_STAGES     = 2;

    typedef enum logic [1:0] {
        IDLE,
        RECEIVE,
        FRAME_END
    } rx_state_e;
endpackage

// File: rtl/spi_frame_receiver_if.sv
// Bundles the SPI pins and the pixel-RAM write / status signals of the
// frame receiver.
//  slave  : the receiver (samples spi_*, drives wr_* and status)
//  master : the SPI host / environment side
`timescale 1ns/1ps
interface spi_frame_receiver_if #(
    parameter int BITS_PER_PIXEL = 16,
    parameter int PIXEL_COUNT    = 1024
);
    localparam int ADDR_W = $clog2(PIXEL_COUNT) + 1;

    logic                      spi_clk;
    logic                      spi_mosi;
    logic                      spi_ss;
    logic                      wr_en;
    logic [ADDR_W-1:0]         wr_addr;
    logic [BITS_PER_PIXEL-1:0] wr_data;
    logic                      display_buffer;
    logic                      frame_done;
    logic                      frame_error;
    logic                      busy;

    modport slave (
        input  spi_clk, spi_mosi, spi_ss,
        output wr_en, wr_addr, wr_data, display_buffer, frame_done, frame_error, busy
    );

    modport master (
        output spi_clk, spi_mosi, spi_ss,
        input  wr_en, wr_addr, wr_data, display_buffer, frame_done, frame_error, busy
    );
endinterface

// File: rtl/spi_frame_receiver_input_sync.sv
// Synchronises the three asynchronous SPI inputs into the clk domain and
// detects the rising edge of the synchronised SPI clock.
//  clk, n_reset              : system clock, async active-low reset
//  spi_clk, spi_mosi, spi_ss : raw SPI pins
//  sclk_rise                 : one-cycle pulse on synced spi_clk 0->1
//  mosi, ss                  : synced data and select
// All three chains have equal depth, so mosi stays aligned with its edge.
`timescale 1ns/1ps
module spi_input_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic n_reset,
    input  logic spi_clk,
    input  logic spi_mosi,
    input  logic spi_ss,
    output logic sclk_rise,
    output logic mosi,
    output logic ss
);
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] ss_sync;
    logic                   sclk_prev;

    // Preset to the idle bus state so reset never fakes an edge or a select.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            ss_sync   <= '1;
            sclk_prev <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], spi_ss};
            sclk_prev <= sclk_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_rise = sclk_sync[SYNC_STAGES-1] & ~sclk_prev;
    assign mosi      = mosi_sync[SYNC_STAGES-1];
    assign ss        = ss_sync[SYNC_STAGES-1];
endmodule

// File: rtl/spi_frame_receiver.sv
// SPI frame receiver: assembles MSB-first pixels from a mode-0 SPI stream
// and writes them into the back half of a double-buffered pixel RAM. The
// front/back flag flips only after an exact-length frame.
//  clk, n_reset : system clock, async active-low reset
//  bus (slave)  : spi_clk/spi_mosi/spi_ss in; wr_en/wr_addr/wr_data,
//                 display_buffer, frame_done, frame_error, busy out
`timescale 1ns/1ps
module spi_frame_receiver #(
    parameter int BITS_PER_PIXEL = spi_frame_receiver_pkg::BITS_PER_PIXEL,
    parameter int PIXEL_COUNT    = spi_frame_receiver_pkg::PIXEL_COUNT,
    parameter int SYNC_STAGES    = spi_frame_receiver_pkg::SYNC_STAGES
) (
    input logic                  clk,
    input logic                  n_reset,
    spi_frame_receiver_if.slave  bus
);
    import spi_frame_receiver_pkg::*;

    localparam int              A        = $clog2(PIXEL_COUNT);
    localparam int              BIT_W    = $clog2(BITS_PER_PIXEL);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(BITS_PER_PIXEL - 1);
    localparam logic [A:0]      FULL     = (A+1)'(PIXEL_COUNT);

    logic sclk_rise;
    logic mosi_s;
    logic ss_s;

    spi_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk      (clk),
        .n_reset  (n_reset),
        .spi_clk  (bus.spi_clk),
        .spi_mosi (bus.spi_mosi),
        .spi_ss   (bus.spi_ss),
        .sclk_rise(sclk_rise),
        .mosi     (mosi_s),
        .ss       (ss_s)
    );

    rx_state_e                 state, state_nxt;
    logic [BITS_PER_PIXEL-2:0] shift_q;
    logic [BIT_W-1:0]          bit_cnt;
    logic [A:0]                pixel_idx;   // one extra bit so it can hold PIXEL_COUNT
    logic                      overflow;
    logic                      take_bit;
    logic                      word_end;
    logic                      frame_ok;
    logic [BITS_PER_PIXEL-1:0] word;

    logic                      wr_en_q;
    logic [A:0]                wr_addr_q;
    logic [BITS_PER_PIXEL-1:0] wr_data_q;
    logic                      disp_q;
    logic                      done_q;
    logic                      err_q;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) state <= IDLE;
        else          state <= state_nxt;
    end

    // Select release beats a coincident clock edge: in RECEIVE a bit is
    // only taken while the synced select is still low.
    always_comb begin
        state_nxt = state;
        take_bit  = 1'b0;
        unique case (state)
            IDLE:      if (!ss_s) state_nxt = RECEIVE;
            RECEIVE: begin
                if (ss_s) state_nxt = FRAME_END;
                else      take_bit  = sclk_rise;
            end
            FRAME_END: state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    assign word     = {shift_q, mosi_s};
    assign word_end = take_bit && (bit_cnt == LAST_BIT);
    assign frame_ok = (pixel_idx == FULL) && (bit_cnt == '0) && !overflow;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            shift_q   <= '0;
            bit_cnt   <= '0;
            pixel_idx <= '0;
            overflow  <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            disp_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;

            if (take_bit) begin
                shift_q <= word[BITS_PER_PIXEL-2:0];
                bit_cnt <= word_end ? '0 : bit_cnt + 1'b1;
                if (word_end) begin
                    // Past the end of the frame: remember it, but never wrap
                    // around and overwrite pixel 0.
                    if (pixel_idx == FULL) begin
                        overflow <= 1'b1;
                    end else begin
                        wr_en_q   <= 1'b1;
                        wr_data_q <= word;
                        wr_addr_q <= {~disp_q, pixel_idx[A-1:0]};
                        pixel_idx <= pixel_idx + 1'b1;
                    end
                end
            end

            if (state == FRAME_END) begin
                if (frame_ok) begin
                    disp_q <= ~disp_q;
                    done_q <= 1'b1;
                end else begin
                    err_q  <= 1'b1;
                end
                shift_q   <= '0;
                bit_cnt   <= '0;
                pixel_idx <= '0;
                overflow  <= 1'b0;
            end
        end
    end

    assign bus.wr_en          = wr_en_q;
    assign bus.wr_addr        = wr_addr_q;
    assign bus.wr_data        = wr_data_q;
    assign bus.display_buffer = disp_q;
    assign bus.frame_done     = done_q;
    assign bus.frame_error    = err_q;
    assign bus.busy           = (state == RECEIVE);
endmodule

// File: tb/tb_spi_frame_receiver.sv
// Randomised bench for spi_frame_receiver with a frame-level reference model.
// A reduced PIXEL_COUNT keeps the run short; spi_clk runs at clk/8.
`timescale 1ns/1ps
module tb_spi_frame_receiver;
    localparam int BPP  = 16;
    localparam int PIX  = 32;
    localparam int AW   = $clog2(PIX);
    localparam int HALF = 4;   // spi_clk half period in clk cycles

    logic clk = 1'b0;
    logic n_reset = 1'b0;
    always #5 clk = ~clk;

    spi_frame_receiver_if #(.BITS_PER_PIXEL(BPP), .PIXEL_COUNT(PIX)) bus ();

    spi_frame_receiver #(
        .BITS_PER_PIXEL(BPP),
        .PIXEL_COUNT   (PIX),
        .SYNC_STAGES   (2)
    ) dut (
        .clk    (clk),
        .n_reset(n_reset),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Write / pulse monitor.
    logic [AW:0]    mon_addr[$];
    logic [BPP-1:0] mon_data[$];
    int             done_cnt = 0;
    int             err_cnt  = 0;

    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            mon_addr.push_back(bus.wr_addr);
            mon_data.push_back(bus.wr_data);
        end
        if (bus.frame_done === 1'b1)  done_cnt++;
        if (bus.frame_error === 1'b1) err_cnt++;
    end

    logic model_disp = 1'b0;

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic v);
        bus.spi_mosi = v;
        wait_clks(HALF);
        bus.spi_clk = 1'b1;
        wait_clks(HALF);
        bus.spi_clk = 1'b0;
    endtask

    // Sends one frame and checks it against the model. clash ends the frame
    // by raising ss together with one more spi_clk rise.
    task automatic run_frame(input string name, input int nwords, input int extra_bits,
                             input bit ramp, input bit clash);
        logic [BPP-1:0] words[$];
        logic [BPP-1:0] w;
        int base_w, base_d, base_e, nexp, got_w;
        bit flip;
        base_w = mon_addr.size();
        base_d = done_cnt;
        base_e = err_cnt;
        for (int i = 0; i < nwords; i++) begin
            w = ramp ? BPP'(i) : BPP'($urandom);
            words.push_back(w);
        end

        bus.spi_ss = 1'b0;
        wait_clks(6);
        chk($sformatf("%s.busy_rx", name), 64'(bus.busy), 64'(1));
        foreach (words[i])
            for (int b = BPP - 1; b >= 0; b--) send_bit(words[i][b]);
        for (int b = 0; b < extra_bits; b++) send_bit(1'($urandom_range(0, 1)));

        if (clash) begin
            bus.spi_mosi = 1'b1;
            wait_clks(HALF);
            bus.spi_clk = 1'b1;
            bus.spi_ss  = 1'b1;
            wait_clks(HALF);
            bus.spi_clk = 1'b0;
        end else begin
            wait_clks(HALF);
            bus.spi_ss = 1'b1;
        end
        wait_clks(8);

        // Model: the first PIX complete words land in the back buffer in
        // order; the frame flips only on exactly PIX words and no stray bits.
        nexp  = (nwords < PIX) ? nwords : PIX;
        flip  = (nwords == PIX) && (extra_bits == 0) && !clash;
        got_w = mon_addr.size() - base_w;
        chk($sformatf("%s.writes", name), 64'(got_w), 64'(nexp));
        for (int i = 0; i < nexp && i < got_w; i++) begin
            chk($sformatf("%s.addr[%0d]", name, i), 64'(mon_addr[base_w + i]),
                64'({~model_disp, AW'(i)}));
            chk($sformatf("%s.data[%0d]", name, i), 64'(mon_data[base_w + i]), 64'(words[i]));
        end
        if (flip) model_disp = ~model_disp;
        chk($sformatf("%s.done", name), 64'(done_cnt - base_d), 64'(flip ? 1 : 0));
        chk($sformatf("%s.error", name), 64'(err_cnt - base_e), 64'(flip ? 0 : 1));
        chk($sformatf("%s.disp", name), 64'(bus.display_buffer), 64'(model_disp));
        chk($sformatf("%s.busy_idle", name), 64'(bus.busy), 64'(0));
    endtask

    task automatic check_reset_outputs(input string name);
        chk($sformatf("%s.wr_en", name), 64'(bus.wr_en), 64'(0));
        chk($sformatf("%s.wr_addr", name), 64'(bus.wr_addr), 64'(0));
        chk($sformatf("%s.wr_data", name), 64'(bus.wr_data), 64'(0));
        chk($sformatf("%s.disp", name), 64'(bus.display_buffer), 64'(0));
        chk($sformatf("%s.done", name), 64'(bus.frame_done), 64'(0));
        chk($sformatf("%s.error", name), 64'(bus.frame_error), 64'(0));
        chk($sformatf("%s.busy", name), 64'(bus.busy), 64'(0));
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "timeout");
    end

    initial begin
        int nw, xb;
        bus.spi_clk  = 1'b0;
        bus.spi_mosi = 1'b0;
        bus.spi_ss   = 1'b1;
        n_reset      = 1'b0;
        wait_clks(3);
        check_reset_outputs("reset");
        n_reset = 1'b1;
        wait_clks(3);
        chk("post_reset.busy", 64'(bus.busy), 64'(0));

        run_frame("full0",  PIX,     0, 1'b1, 1'b0);
        run_frame("full1",  PIX,     0, 1'b1, 1'b0);
        run_frame("short",  PIX - 1, 0, 1'b0, 1'b0);
        run_frame("ragged", PIX,     5, 1'b0, 1'b0);
        run_frame("long",   PIX + 1, 0, 1'b0, 1'b0);
        run_frame("rand",   PIX,     0, 1'b0, 1'b0);

        // Abort a frame part-way through with reset.
        bus.spi_ss = 1'b0;
        wait_clks(6);
        for (int i = 0; i < PIX / 2 + 3; i++)
            for (int b = BPP - 1; b >= 0; b--) send_bit(1'($urandom_range(0, 1)));
        n_reset = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        model_disp  = 1'b0;
        bus.spi_ss  = 1'b1;
        bus.spi_clk = 1'b0;
        wait_clks(3);
        n_reset = 1'b1;
        wait_clks(3);

        run_frame("post_rst", PIX, 0, 1'b0, 1'b0);
        run_frame("clash",    0,  15, 1'b0, 1'b1);

        for (int k = 0; k < 2; k++) begin
            nw = $urandom_range(PIX - 2, PIX + 1);
            xb = ($urandom_range(0, 2) == 0) ? $urandom_range(1, BPP - 1) : 0;
            run_frame($sformatf("rand_len%0d", k), nw, xb, 1'b0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
